afifo_burst_reader: RTL and testbench

- Read-side consumer for the team's asynchronous FIFO. Runs entirely in the FIFO's read clock domain (rclk).
- On a command it pops exactly cmd_len words through the FIFO read port (rtrigger/rdata/rok).
- Popped words are delivered on a valid/ready output stream through a 2-entry internal skid buffer. The final word is flagged with out_last, and a one-cycle done pulse marks burst completion.

---
 rtl/afifo_burst_reader.sv | 160 ++++++++++++++++
 tb/tb_afifo_burst_reader.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/afifo_burst_reader.sv
// Read-side burst consumer for the async FIFO: pops cmd_len words into a 2-entry skid buffer and streams them out.
// Optional stall abort is compiled in with `define FIFO_READER_TIMEOUT_EN.
module afifo_burst_reader #(
  parameter int Width         = 12,
  parameter int LenWidth      = 8,
  parameter int TimeoutCycles = 16
) (
  input  logic                rclk,
  input  logic                dirclr,
  input  logic                cmd_trigger,
  input  logic [LenWidth-1:0] cmd_len,
  output logic                cmd_ready,
  output logic                fifo_rtrigger,
  input  logic [Width-1:0]    fifo_rdata,
  input  logic                fifo_rok,
  output logic                out_valid,
  output logic [Width-1:0]    out_data,
  output logic                out_last,
  input  logic                out_ready,
  output logic                done,
`ifdef FIFO_READER_TIMEOUT_EN
  output logic                timeout,
`endif
  output logic [LenWidth-1:0] words_read
);

  if (TimeoutCycles < 1) begin : g_bad_timeout
    $error("afifo_burst_reader: TimeoutCycles must be >= 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_READ, S_DONE} state_t;

  state_t              state_q, state_d;
  logic [LenWidth-1:0] remaining_q, remaining_d;
  logic [LenWidth-1:0] words_read_q, words_read_d;
  logic [1:0]          count_q, count_d;
  logic                wr_ptr_q, wr_ptr_d;
  logic                rd_ptr_q, rd_ptr_d;
  logic [Width-1:0]    buf_dat_q [2];
  logic [Width-1:0]    buf_dat_d [2];
  logic [1:0]          buf_last_q, buf_last_d;
  logic                push, pull;

`ifdef FIFO_READER_TIMEOUT_EN
  localparam int StallW = $clog2(TimeoutCycles + 1);
  logic [StallW-1:0] stall_q, stall_d;
  logic              timed_out_q, timed_out_d;
  assign timeout = (state_q == S_DONE) && timed_out_q;
`endif

  // Pop request depends only on flops, so out_ready/fifo_rok never reach it combinationally.
  assign fifo_rtrigger = (state_q == S_READ) && (remaining_q != '0) && (count_q != 2'd2);
  assign push          = fifo_rtrigger && fifo_rok;
  assign out_valid     = (count_q != 2'd0);
  assign pull          = out_valid && out_ready;
  assign out_data      = out_valid ? buf_dat_q[rd_ptr_q] : '0;
  assign out_last      = out_valid && buf_last_q[rd_ptr_q];
  assign cmd_ready     = (state_q == S_IDLE);
  assign done          = (state_q == S_DONE);
  assign words_read    = words_read_q;

  always_comb begin
    state_d      = state_q;
    remaining_d  = remaining_q;
    words_read_d = words_read_q;
    count_d      = count_q;
    wr_ptr_d     = wr_ptr_q;
    rd_ptr_d     = rd_ptr_q;
    buf_dat_d    = buf_dat_q;
    buf_last_d   = buf_last_q;
`ifdef FIFO_READER_TIMEOUT_EN
    stall_d      = stall_q;
    timed_out_d  = timed_out_q;
`endif

    if (push) begin
      buf_dat_d[wr_ptr_q]  = fifo_rdata;
      buf_last_d[wr_ptr_q] = (remaining_q == LenWidth'(1));
      wr_ptr_d             = ~wr_ptr_q;
      remaining_d          = remaining_q - LenWidth'(1);
      words_read_d         = words_read_q + LenWidth'(1);
    end
    if (pull) rd_ptr_d = ~rd_ptr_q;

    case ({push, pull})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase

`ifdef FIFO_READER_TIMEOUT_EN
    // Abort by zeroing remaining: already-buffered words still drain, no out_last is ever tagged.
    if (push) begin
      stall_d = '0;
    end else if (fifo_rtrigger && !fifo_rok) begin
      if (stall_q == StallW'(TimeoutCycles - 1)) begin
        stall_d     = '0;
        remaining_d = '0;
        timed_out_d = 1'b1;
      end else begin
        stall_d = stall_q + StallW'(1);
      end
    end
`endif

    case (state_q)
      S_IDLE: begin
        if (cmd_trigger) begin
          words_read_d = '0;
          remaining_d  = cmd_len;
          state_d      = (cmd_len != '0) ? S_READ : S_DONE;
`ifdef FIFO_READER_TIMEOUT_EN
          stall_d      = '0;
          timed_out_d  = 1'b0;
`endif
        end
      end
      S_READ: begin
        if (pull && out_last && (remaining_q == '0)) state_d = S_DONE;
`ifdef FIFO_READER_TIMEOUT_EN
        if (timed_out_q && (count_q == 2'd0)) state_d = S_DONE;
`endif
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge rclk or posedge dirclr) begin
    if (dirclr) begin
      state_q      <= S_IDLE;
      remaining_q  <= '0;
      words_read_q <= '0;
      count_q      <= 2'd0;
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      buf_dat_q[0] <= '0;
      buf_dat_q[1] <= '0;
      buf_last_q   <= 2'b00;
`ifdef FIFO_READER_TIMEOUT_EN
      stall_q      <= '0;
      timed_out_q  <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      remaining_q  <= remaining_d;
      words_read_q <= words_read_d;
      count_q      <= count_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      buf_dat_q    <= buf_dat_d;
      buf_last_q   <= buf_last_d;
`ifdef FIFO_READER_TIMEOUT_EN
      stall_q      <= stall_d;
      timed_out_q  <= timed_out_d;
`endif
    end
  end

endmodule

// File: tb/tb_afifo_burst_reader.sv
// Bench for afifo_burst_reader: behavioural FIFO plus a queue model of FIFO contents and burst rules.
module tb_afifo_burst_reader;

  logic        rclk = 1'b0;
  logic        dirclr = 1'b1;
  logic        cmd_trigger = 1'b0;
  logic [7:0]  cmd_len = 8'd0;
  logic        cmd_ready;
  logic        fifo_rtrigger;
  logic [11:0] fifo_rdata;
  logic        fifo_rok;
  logic        out_valid;
  logic [11:0] out_data;
  logic        out_last;
  logic        out_ready = 1'b0;
  logic        done;
  logic [7:0]  words_read;
`ifdef FIFO_READER_TIMEOUT_EN
  logic        timeout_o;
`endif

  afifo_burst_reader dut (
    .rclk          (rclk),
    .dirclr        (dirclr),
    .cmd_trigger   (cmd_trigger),
    .cmd_len       (cmd_len),
    .cmd_ready     (cmd_ready),
    .fifo_rtrigger (fifo_rtrigger),
    .fifo_rdata    (fifo_rdata),
    .fifo_rok      (fifo_rok),
    .out_valid     (out_valid),
    .out_data      (out_data),
    .out_last      (out_last),
    .out_ready     (out_ready),
    .done          (done),
`ifdef FIFO_READER_TIMEOUT_EN
    .timeout       (timeout_o),
`endif
    .words_read    (words_read)
  );

  always #5 rclk = ~rclk;

  // Behavioural FIFO read side: 256-entry ring, combinational rdata, pop on rtrigger && rok.
  logic [11:0] fmem [0:255];
  logic [7:0]  fwr = 8'd0;
  logic [7:0]  frd = 8'd0;
  assign fifo_rok   = (fwr != frd);
  assign fifo_rdata = fmem[frd];
  always @(posedge rclk) if (fifo_rtrigger && fifo_rok) frd <= frd + 8'd1;

  int tests = 0;
  int fails = 0;
  logic [11:0] model_q[$];
  logic [11:0] pend_q[$];

  task automatic fifo_push(input logic [11:0] w);
    fmem[fwr] = w;
    fwr = fwr + 8'd1;
    model_q.push_back(w);
  endtask

  // Issue one command at the current negedge and follow it to done.
  // feed: 0 preload, 1 one word every 5 cycles. rmode: 0 ready=1, 1 pattern 1,0,0, 2 random.
  task automatic run_burst(input int len, input int n_new, input int feed, input int rmode);
    int acc, pops, cyc, last_cyc, occ;
    bit got_done, exp_trig;
    acc = 0; pops = 0; cyc = 0; last_cyc = -1; got_done = 0;
    pend_q.delete();
    for (int i = 0; i < n_new; i++) pend_q.push_back(12'($urandom));
    if (feed == 0) while (pend_q.size() != 0) fifo_push(pend_q.pop_front());
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL cmd_ready_before_cmd got %b exp 1", cmd_ready); end
    cmd_len = 8'(len);
    cmd_trigger = 1'b1;
    @(negedge rclk);
    while (!got_done && cyc < 3000) begin
      cmd_trigger = 1'($urandom);
      cmd_len = 8'($urandom);
      if (feed == 1 && (cyc % 5) == 0 && pend_q.size() != 0) fifo_push(pend_q.pop_front());
      case (rmode)
        0:       out_ready = 1'b1;
        1:       out_ready = ((cyc % 3) == 0);
        default: out_ready = 1'($urandom);
      endcase
      #1;
      occ = pops - acc;
      exp_trig = (pops < len) && (occ < 2);
      tests++;
      if (out_valid !== (occ != 0)) begin fails++; $display("FAIL out_valid cyc %0d got %b exp %b", cyc, out_valid, occ != 0); end
      tests++;
      if (fifo_rtrigger !== exp_trig) begin fails++; $display("FAIL rtrigger cyc %0d got %b exp %b", cyc, fifo_rtrigger, exp_trig); end
      tests++;
      if (words_read !== 8'(pops)) begin fails++; $display("FAIL words_read_live got %0d exp %0d", words_read, pops); end
      if (done) begin
        got_done = 1;
        tests++;
        if (acc != len || cyc != last_cyc + 1 || words_read !== 8'(len) || cmd_ready !== 1'b0) begin
          fails++; $display("FAIL done_timing acc %0d/%0d cyc %0d exp %0d words_read %0d", acc, len, cyc, last_cyc + 1, words_read);
        end
`ifdef FIFO_READER_TIMEOUT_EN
        tests++;
        if (timeout_o !== 1'b0) begin fails++; $display("FAIL timeout_normal got %b exp 0", timeout_o); end
`endif
      end else if (out_valid && out_ready) begin
        tests++;
        if (acc >= len || out_data !== model_q[acc] || out_last !== (acc == len - 1)) begin
          fails++; $display("FAIL out_word idx %0d got %h/%b exp %h/%b", acc, out_data, out_last,
                            (acc < len) ? model_q[acc] : 12'h0, acc == len - 1);
        end
        acc++;
        last_cyc = cyc;
      end
      if (fifo_rtrigger && fifo_rok) pops++;
      if (!got_done) begin @(negedge rclk); cyc++; end
    end
    cmd_trigger = 1'b0;
    tests++;
    if (!got_done) begin fails++; $display("FAIL burst_no_done len %0d got acc %0d exp done", len, acc); end
    for (int i = 0; i < len && model_q.size() != 0; i++) void'(model_q.pop_front());
    @(negedge rclk);
    #1;
    tests++;
    if (cmd_ready !== 1'b1 || done !== 1'b0) begin fails++; $display("FAIL after_done cmd_ready %b done %b exp 1 0", cmd_ready, done); end
  endtask

  task automatic test_reset;
    out_ready = 1'b0;
    dirclr = 1'b1;
    repeat (3) @(negedge rclk);
    #1;
    tests++;
    if (out_valid !== 1'b0 || fifo_rtrigger !== 1'b0 || done !== 1'b0 || words_read !== 8'd0 ||
        out_last !== 1'b0 || out_data !== 12'd0) begin
      fails++; $display("FAIL reset_outputs got v%b t%b d%b wr%0d l%b dat%h exp all 0",
                        out_valid, fifo_rtrigger, done, words_read, out_last, out_data);
    end
    dirclr = 1'b0;
    @(negedge rclk);
    #1;
    tests++;
    if (cmd_ready !== 1'b1) begin fails++; $display("FAIL reset_cmd_ready got %b exp 1", cmd_ready); end
  endtask

  task automatic test_basic;
    for (int i = 1; i <= 4; i++) fifo_push(12'(i));
    run_burst(4, 0, 0, 0);
  endtask

  task automatic test_backpressure;
    run_burst(6, 6, 0, 1);
  endtask

  task automatic test_starved;
    run_burst(3, 3, 1, 0);
  endtask

  task automatic test_zero_len;
    run_burst(0, 0, 0, 0);
  endtask

  task automatic test_back_to_back;
    for (int i = 0; i < 8; i++) begin
      int l;
      l = $urandom_range(1, 20);
      run_burst(l, l, $urandom_range(0, 1), $urandom_range(0, 2));
    end
  endtask

  task automatic test_max_len;
    run_burst(255, 255, 0, 2);
  endtask

  task automatic test_reset_mid_burst;
    for (int i = 0; i < 5; i++) fifo_push(12'($urandom));
    out_ready = 1'b0;
    cmd_len = 8'd5;
    cmd_trigger = 1'b1;
    @(negedge rclk);
    cmd_trigger = 1'b0;
    repeat (3) @(negedge rclk);
    #1;
    tests++;
    if (fifo_rtrigger !== 1'b0 || out_valid !== 1'b1 || 8'(fwr - frd) !== 8'd3) begin
      fails++; $display("FAIL skid_full rtrigger %b valid %b level %0d exp 0 1 3", fifo_rtrigger, out_valid, 8'(fwr - frd));
    end
    dirclr = 1'b1;
    #1;
    tests++;
    if (out_valid !== 1'b0 || fifo_rtrigger !== 1'b0 || done !== 1'b0 || words_read !== 8'd0 || out_last !== 1'b0) begin
      fails++; $display("FAIL midreset_outputs got v%b t%b d%b wr%0d l%b exp 0", out_valid, fifo_rtrigger, done, words_read, out_last);
    end
    @(negedge rclk);
    dirclr = 1'b0;
    @(negedge rclk);
    #1;
    void'(model_q.pop_front());
    void'(model_q.pop_front());
    tests++;
    if (cmd_ready !== 1'b1 || 8'(fwr - frd) !== 8'd3 || fifo_rdata !== model_q[0]) begin
      fails++; $display("FAIL midreset_retain cmd_ready %b level %0d head %h exp 1 3 %h", cmd_ready, 8'(fwr - frd), fifo_rdata, model_q[0]);
    end
    run_burst(3, 0, 0, 2);
  endtask

`ifdef FIFO_READER_TIMEOUT_EN
  task automatic test_timeout;
    int acc, pops, stalls, cyc;
    bit got_done;
    acc = 0; pops = 0; stalls = 0; cyc = 0; got_done = 0;
    fifo_push(12'($urandom));
    fifo_push(12'($urandom));
    out_ready = 1'b1;
    cmd_len = 8'd5;
    cmd_trigger = 1'b1;
    @(negedge rclk);
    cmd_trigger = 1'b0;
    while (!got_done && cyc < 200) begin
      #1;
      if (done) begin
        got_done = 1;
        tests++;
        if (timeout_o !== 1'b1 || words_read !== 8'd2 || acc != 2 || stalls != 16) begin
          fails++; $display("FAIL timeout_done timeout %b words_read %0d acc %0d stalls %0d exp 1 2 2 16", timeout_o, words_read, acc, stalls);
        end
      end else if (out_valid && out_ready) begin
        tests++;
        if (acc >= 2 || out_data !== model_q[acc] || out_last !== 1'b0) begin
          fails++; $display("FAIL timeout_word idx %0d got %h/%b exp %h/0", acc, out_data, out_last, (acc < 2) ? model_q[acc] : 12'h0);
        end
        acc++;
      end
      if (fifo_rtrigger && fifo_rok) pops++;
      if (fifo_rtrigger && !fifo_rok) stalls++;
      if (!got_done) begin @(negedge rclk); cyc++; end
    end
    tests++;
    if (!got_done) begin fails++; $display("FAIL timeout_no_done got acc %0d exp done", acc); end
    void'(model_q.pop_front());
    void'(model_q.pop_front());
    @(negedge rclk);
    #1;
    tests++;
    if (cmd_ready !== 1'b1 || timeout_o !== 1'b0) begin fails++; $display("FAIL timeout_after cmd_ready %b timeout %b exp 1 0", cmd_ready, timeout_o); end
  endtask
`endif

  initial begin
    test_reset;
    test_basic;
    test_backpressure;
    test_starved;
    test_zero_len;
    test_back_to_back;
    test_max_len;
    test_reset_mid_burst;
`ifdef FIFO_READER_TIMEOUT_EN
    test_timeout;
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
